// File: rtl/fifo_pkg.sv
// Shared definitions for the BRAM FIFO read-side drain engine.
package fifo_pkg;

  localparam int FIFO_RD_BUF_DEPTH = 3;
  localparam int FIFO_RD_BUF_PTR_W = 2;
  localparam int FIFO_RD_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_POP  = 2'b01,
    BUF_PUSH = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  function automatic logic [FIFO_RD_BUF_PTR_W-1:0] buf_ptr_next(
    input logic [FIFO_RD_BUF_PTR_W-1:0] ptr
  );
    logic [FIFO_RD_BUF_PTR_W-1:0] nxt_s;
    if (ptr == FIFO_RD_BUF_PTR_W'(FIFO_RD_BUF_DEPTH - 1)) begin
      nxt_s = {FIFO_RD_BUF_PTR_W{1'b0}};
    end else begin
      nxt_s = ptr + FIFO_RD_BUF_PTR_W'(1);
    end
    return nxt_s;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Three-entry register skid buffer with circular pointers and occupancy count.
module fifo_rd_stream_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        head_data,
  output logic [FIFO_RD_BUF_PTR_W-1:0] cnt
);

  logic [DATA_WIDTH-1:0]        mem_r [FIFO_RD_BUF_DEPTH];
  logic [FIFO_RD_BUF_PTR_W-1:0] wr_ptr_r;
  logic [FIFO_RD_BUF_PTR_W-1:0] rd_ptr_r;
  logic [FIFO_RD_BUF_PTR_W-1:0] cnt_r;
  buf_op_e                      op_s;

  // Decode the push/pop pair into a single buffer operation.
  always_comb begin
    op_s = buf_op_e'({push, pop});
  end

  // Entry storage: the word captured from the FIFO lands at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_RD_BUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy update; push with pop keeps the count steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      case (op_s)
        BUF_PUSH: begin
          wr_ptr_r <= buf_ptr_next(wr_ptr_r);
          cnt_r    <= cnt_r + FIFO_RD_BUF_PTR_W'(1);
        end
        BUF_POP: begin
          rd_ptr_r <= buf_ptr_next(rd_ptr_r);
          cnt_r    <= cnt_r - FIFO_RD_BUF_PTR_W'(1);
        end
        BUF_BOTH: begin
          wr_ptr_r <= buf_ptr_next(wr_ptr_r);
          rd_ptr_r <= buf_ptr_next(rd_ptr_r);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign cnt       = cnt_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine: credit-based pops into a valid/ready stream.
// Optional delivered-word counter port m_count enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = FIFO_RD_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  m_count
`endif
);

  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("CNT_WIDTH must be at least 1");
  end

  logic                         run_r;
  logic                         rd_q_r;
  logic [FIFO_RD_BUF_PTR_W-1:0] buf_cnt_s;
  logic [FIFO_RD_BUF_PTR_W:0]   credit_s;
  logic                         xfer_s;

  // Words owed to the buffer (held plus in flight) bound further pops.
  always_comb begin
    credit_s   = {1'b0, buf_cnt_s} + {{FIFO_RD_BUF_PTR_W{1'b0}}, rd_q_r};
    fifo_rd_en = run_r && !fifo_empty &&
                 (credit_s < (FIFO_RD_BUF_PTR_W + 1)'(FIFO_RD_BUF_DEPTH));
  end

  assign m_valid = (buf_cnt_s != {FIFO_RD_BUF_PTR_W{1'b0}});
  assign xfer_s  = m_valid && m_ready;

  // Start-up gate and one-cycle tracking of the FIFO read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r  <= 1'b0;
      rd_q_r <= 1'b0;
    end else begin
      run_r  <= 1'b1;
      rd_q_r <= fifo_rd_en;
    end
  end

  fifo_rd_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_q_r),
    .push_data (fifo_data),
    .pop       (xfer_s),
    .head_data (m_data),
    .cnt       (buf_cnt_s)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] count_r;

  // Delivered-word counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (xfer_s) begin
      count_r <= count_r + CNT_WIDTH'(1);
    end
  end

  assign m_count = count_r;
`endif

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the team's synchronous BRAM FIFO. It issues `fifo_rd_en` pops against the FIFO's empty flag and absorbs the FIFO's one-cycle registered read latency. It presents the words as a valid/ready stream with full throughput and no loss under backpressure. It sits between the FIFO's read port and any downstream consumer that speaks valid/ready.

## Interface
- `DATA_WIDTH`, 32: word width; must match the FIFO.
- `CNT_WIDTH`, 32: width of the delivered-word counter (used only with the macro).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop; FIFO data is valid on `fifo_data` in the following cycle.
- `fifo_data` in DATA_WIDTH: FIFO registered read data.
- `m_valid` out 1: output word valid.
- `m_data` out DATA_WIDTH: output word.
- `m_ready` in 1: consumer accepts; a transfer occurs when `m_valid && m_ready`.
- `m_count` out CNT_WIDTH: present only with `FIFO_RD_STREAM_CNT_EN`.

## Operation
- Internal 3-entry circular buffer: write pointer, read pointer, 2-bit occupancy `buf_cnt` (0..3).
- `rd_q`: registered copy of `fifo_rd_en`, marks one read in flight.
- `run`: flag, reset 0, set to 1 on the first clock edge after `rst_n` rises.
- `fifo_rd_en = run && !fifo_empty && (buf_cnt + rd_q) < 3`.
  - Purely a function of registers and `fifo_empty`.
  - No combinational path from `m_ready`.
- Capture: when `rd_q` is 1, `fifo_data` is written to the buffer at the write pointer on that edge.
- Pop: a transfer frees the head entry.
- Simultaneous capture and pop in one cycle leaves `buf_cnt` unchanged. Both pointers advance.
- Pointers wrap 2→0. `buf_cnt` never exceeds 3; the credit rule guarantees this, so no overflow check is required.
- `m_valid = (buf_cnt != 0)`. `m_data` is the head entry, read directly from the register array.
- Ordering is strictly FIFO. Every popped word is delivered exactly once.
- `fifo_rd_en` is never asserted while `fifo_empty` is 1.
- Reset mid-operation:
  - All state clears immediately.
  - In-flight and buffered words are discarded.
  - The FIFO is expected to be reset by the same `rst_n`.

## Timing
- Reset values: `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `m_count` 0, `buf_cnt` 0, `rd_q` 0, `run` 0.
- `fifo_rd_en` stays 0 during reset and for the first cycle after release.
- Latency: `fifo_rd_en` high in cycle N, then `fifo_data` valid in N+1, then `m_valid`/`m_data` in N+2.
- Throughput: with `m_ready` held 1 and the FIFO non-empty, one word per cycle sustained. `buf_cnt` settles at 1 with `rd_q` = 1.
- Backpressure: with `m_ready` held 0, at most 3 pops are issued, then `fifo_rd_en` stays 0. On release, delivery resumes next cycle with no bubble beyond the refill latency.
- Under `m_ready` = 0, `m_valid` and `m_data` hold stable.

## Configuration
- `FIFO_RD_STREAM_CNT_EN` defined:
  - `m_count` port exists.
  - It increments by 1 on each transfer and wraps modulo 2^CNT_WIDTH.
  - It resets to 0.
- Not defined: no port, no counter logic. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg` holds:
  - `FIFO_RD_BUF_DEPTH` = 3
  - `FIFO_RD_BUF_PTR_W` = 2
  - the default `CNT_WIDTH`
- One sub-module: `fifo_rd_stream_buf`. This is the 3-entry register buffer with pointers, occupancy, and push/pop ports. The top holds the credit logic, `run`, `rd_q`, and the counter.

## Test plan
- Reset: assert `rst_n` = 0 with `fifo_empty` = 0. Required: `fifo_rd_en` = 0 and `m_valid` = 0 throughout, and `fifo_rd_en` still 0 in the first cycle after release.
- Single word: FIFO holds 0xA5A5_0001, `m_ready` = 1. Required: `fifo_rd_en` pulses once at N, then `m_valid` is 1 with `m_data` = 0xA5A5_0001 at N+2 for exactly one cycle.
- Streaming: 8 words 1..8, `m_ready` = 1. Required: 8 consecutive cycles of `m_valid`, in order, no gaps after the first word, and `fifo_rd_en` never high while empty.
- Backpressure: 10 words, `m_ready` = 0 for 20 cycles. Required: exactly 3 `fifo_rd_en` pulses, `m_data` held at word 1. Then with `m_ready` = 1, all 10 words arrive in order with no duplicates or losses.
- Random `m_ready` (50%) over 1000 words. Required: the scoreboard matches exactly. With `FIFO_RD_STREAM_CNT_EN`, `m_count` = 1000 at the end; with `CNT_WIDTH` = 4, `m_count` = 1000 mod 16 = 8.
- Reset mid-burst: after 5 of 10 words are delivered, pulse `rst_n` low for 1 cycle, then refill the FIFO with 3 words. Required: outputs return to reset values at once, and only the 3 new words are delivered afterwards.
